// File: rtl/line_measure_pkg.sv
// Shared types for the line_measure video timing measurement block.
package line_measure_pkg;

  localparam int ACT_W = 12;
  localparam int TOT_W = 12;
  localparam int LIN_W = 11;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  typedef struct packed {
    logic [ACT_W-1:0] act;
    logic [TOT_W-1:0] tot;
    logic [LIN_W-1:0] lines;
    logic             intl;
  } meas_t;

endpackage

// File: rtl/hvf_edge_detect.sv
// Input register for the HVF flags plus registered rise/fall strobes.
module hvf_edge_detect (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hvf_in,
  output logic [2:0] hvf_lvl,
  output logic [2:0] hvf_rise,
  output logic [2:0] hvf_fall
);

  logic [2:0] s1_reg;
  logic [2:0] s2_reg;
  logic [1:0] primed_reg;

  // Strobes stay quiet until s2 holds a real sample, so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg     <= '0;
      s2_reg     <= '0;
      primed_reg <= '0;
      hvf_lvl    <= '0;
      hvf_rise   <= '0;
      hvf_fall   <= '0;
    end else begin
      s1_reg     <= hvf_in;
      s2_reg     <= s1_reg;
      primed_reg <= {primed_reg[0], 1'b1};
      hvf_lvl    <= s1_reg;
      hvf_rise   <= primed_reg[1] ? (s1_reg & ~s2_reg) : 3'b000;
      hvf_fall   <= primed_reg[1] ? (~s1_reg & s2_reg) : 3'b000;
    end
  end

endmodule

// File: rtl/line_measure.sv
// Measures active/total samples per line, lines per frame and scan type; locks after
// LOCK_FRAMES identical frames. Optional LINE_MEASURE_WATCHDOG_EN drops lock on a dead input.
module line_measure
  import line_measure_pkg::*;
#(
  parameter int LOCK_FRAMES = 3,
  parameter int TIMEOUT     = 8192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       hvf_in,
  output logic [ACT_W-1:0] number_active,
  output logic [TOT_W-1:0] samples_per_line,
  output logic [LIN_W-1:0] lines_per_frame,
  output logic             interlaced,
  output logic             is_ok,
  output logic             fmt_change
);

  localparam logic [ACT_W-1:0] ACT_MAX   = '1;
  localparam logic [TOT_W-1:0] TOT_MAX   = '1;
  localparam logic [LIN_W-1:0] LIN_MAX   = '1;
  localparam logic [3:0]       MATCH_MAX = '1;
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_FRAMES);

  logic [2:0] lvl, rise, fall;
  logic h_rise, h_fall, prev_v, frame_bnd, wd_expire, unused_sink;

  hvf_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .hvf_in   (hvf_in),
    .hvf_lvl  (lvl),
    .hvf_rise (rise),
    .hvf_fall (fall)
  );

  assign h_rise      = rise[0];
  assign h_fall      = fall[0];
  // V level of the cycle before, i.e. of the line that an H rise is closing.
  assign prev_v      = (lvl[1] & ~rise[1]) | fall[1];
  assign frame_bnd   = rise[1] & ~lvl[2];
  assign unused_sink = ^{rise[2], fall[2], (TIMEOUT > 0)};

  logic [ACT_W-1:0] act_cnt_reg, line_act_reg, line_act_next;
  logic [TOT_W-1:0] tot_cnt_reg, prev_tot_reg;
  logic [LIN_W-1:0] line_cnt_reg, lines_now;
  logic have_prev_reg, line_err_reg, sat_reg, f_seen_reg;
  logic sat_now, tot_err, meas_valid;
  meas_t meas;

  always_comb begin
    line_act_next = (h_rise && !prev_v) ? act_cnt_reg : line_act_reg;
    lines_now     = !h_rise ? line_cnt_reg :
                    (line_cnt_reg == LIN_MAX) ? LIN_MAX : line_cnt_reg + 1'b1;
    sat_now       = (act_cnt_reg == ACT_MAX) || (tot_cnt_reg == TOT_MAX) || (line_cnt_reg == LIN_MAX);
    tot_err       = h_rise && have_prev_reg && (tot_cnt_reg != prev_tot_reg);
    meas          = '{act: line_act_next, tot: tot_cnt_reg, lines: lines_now, intl: f_seen_reg | lvl[2]};
    meas_valid    = !(line_err_reg || tot_err || sat_reg || sat_now);
  end

  // Counters include the current cycle when they restart, so a closed line reads its true length.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_cnt_reg   <= '0;
      tot_cnt_reg   <= '0;
      line_act_reg  <= '0;
      prev_tot_reg  <= '0;
      line_cnt_reg  <= '0;
      have_prev_reg <= 1'b0;
      line_err_reg  <= 1'b0;
      sat_reg       <= 1'b0;
      f_seen_reg    <= 1'b0;
    end else begin
      if (h_fall)
        act_cnt_reg <= {{(ACT_W-1){1'b0}}, ~lvl[1]};
      else if (!lvl[0] && !lvl[1] && act_cnt_reg != ACT_MAX)
        act_cnt_reg <= act_cnt_reg + 1'b1;
      if (h_rise)
        tot_cnt_reg <= {{(TOT_W-1){1'b0}}, 1'b1};
      else if (tot_cnt_reg != TOT_MAX)
        tot_cnt_reg <= tot_cnt_reg + 1'b1;
      sat_reg    <= sat_reg | sat_now;
      f_seen_reg <= f_seen_reg | lvl[2];
      if (h_rise) begin
        line_act_reg  <= line_act_next;
        prev_tot_reg  <= tot_cnt_reg;
        have_prev_reg <= 1'b1;
        line_cnt_reg  <= lines_now;
        line_err_reg  <= line_err_reg | tot_err;
      end
      if (frame_bnd) begin
        line_cnt_reg  <= '0;
        have_prev_reg <= 1'b0;
        line_err_reg  <= 1'b0;
        sat_reg       <= 1'b0;
        f_seen_reg    <= 1'b0;
      end
    end
  end

`ifdef LINE_MEASURE_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd_cnt_reg;

  assign wd_expire = !h_rise && (wd_cnt_reg == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || h_rise || wd_expire)
      wd_cnt_reg <= '0;
    else
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
  end
`else
  assign wd_expire = 1'b0;
`endif

  state_t state_reg, state_next;
  logic [3:0] match_reg, match_next;
  meas_t ref_reg, ref_next, out_reg;
  logic load_out, fmt_next, is_ok_reg, fmt_reg;

  always_comb begin
    state_next = state_reg;
    match_next = match_reg;
    ref_next   = ref_reg;
    fmt_next   = 1'b0;
    load_out   = 1'b0;
    case (state_reg)
      SEARCH: if (frame_bnd) begin
        state_next = TRACK;
        match_next = '0;
      end
      TRACK: if (frame_bnd) begin
        if (!meas_valid)
          match_next = '0;
        else if (meas == ref_reg)
          match_next = (match_reg == MATCH_MAX) ? match_reg : match_reg + 1'b1;
        else begin
          ref_next   = meas;
          match_next = 4'd1;
        end
        if (match_next >= LOCK_N) state_next = LOCKED;
        load_out = (match_next != 4'd0);
      end
      LOCKED: if (frame_bnd) begin
        if (meas_valid && meas == ref_reg)
          load_out = 1'b1;
        else begin
          state_next = TRACK;
          fmt_next   = 1'b1;
          ref_next   = meas;
          match_next = meas_valid ? 4'd1 : 4'd0;
          load_out   = meas_valid;
        end
      end
      default: state_next = SEARCH;
    endcase
    if (wd_expire) begin
      state_next = SEARCH;
      match_next = '0;
      load_out   = 1'b0;
      fmt_next   = (state_reg == LOCKED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SEARCH;
      match_reg <= '0;
      ref_reg   <= '0;
      out_reg   <= '0;
      is_ok_reg <= 1'b0;
      fmt_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      match_reg <= match_next;
      ref_reg   <= ref_next;
      if (load_out) out_reg <= ref_next;
      is_ok_reg <= (state_next == LOCKED);
      fmt_reg   <= fmt_next;
    end
  end

  assign number_active    = out_reg.act;
  assign samples_per_line = out_reg.tot;
  assign lines_per_frame  = out_reg.lines;
  assign interlaced       = out_reg.intl;
  assign is_ok            = is_ok_reg;
  assign fmt_change       = fmt_reg;

endmodule

// File: tb/tb_line_measure.sv
// Scoreboard bench for line_measure: a frame-level lock model predicts outputs per frame boundary.
module tb_line_measure;

  localparam int LF = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  hvf_in = 3'b000;
  logic [11:0] number_active, samples_per_line;
  logic [10:0] lines_per_frame;
  logic        interlaced, is_ok, fmt_change;

  line_measure #(.LOCK_FRAMES(LF), .TIMEOUT(8192)) dut (
    .clk              (clk),
    .reset            (reset),
    .hvf_in           (hvf_in),
    .number_active    (number_active),
    .samples_per_line (samples_per_line),
    .lines_per_frame  (lines_per_frame),
    .interlaced       (interlaced),
    .is_ok            (is_ok),
    .fmt_change       (fmt_change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic        ok;
    logic        fmt;
    logic [35:0] out;
  } exp_t;

  exp_t sbq[$];

  int          m_state = 0;
  int          m_match = 0;
  logic [35:0] m_ref = '0, m_out = '0, prev_meas = '0;
  bit          prev_valid = 1'b0;
  int          fmt_exp = 0, fmt_seen = 0;

  task automatic push(input int due, input logic ok, input logic fmt, input logic [35:0] out);
    exp_t e;
    e.due = due; e.ok = ok; e.fmt = fmt; e.out = out;
    sbq.push_back(e);
  endtask

  // Expected lock behaviour at a frame boundary closing the frame described by prev_meas.
  task automatic boundary();
    bit load, fmt;
    load = 1'b0;
    fmt  = 1'b0;
    case (m_state)
      0: begin m_state = 1; m_match = 0; end
      1: begin
        if (!prev_valid) m_match = 0;
        else if (prev_meas == m_ref) m_match = (m_match < 15) ? m_match + 1 : 15;
        else begin m_ref = prev_meas; m_match = 1; end
        if (m_match >= LF) m_state = 2;
        load = (m_match >= 1);
      end
      default: begin
        if (prev_valid && prev_meas == m_ref) load = 1'b1;
        else begin
          m_state = 1; fmt = 1'b1; m_ref = prev_meas;
          m_match = prev_valid ? 1 : 0;
          load = (m_match >= 1);
        end
      end
    endcase
    if (load) m_out = m_ref;
    if (fmt) fmt_exp++;
    push(cyc + 3, m_state == 2, fmt, m_out);
    push(cyc + 4, m_state == 2, 1'b0, m_out);
  endtask

  task automatic model_reset();
    m_state = 0; m_match = 0; m_ref = '0; m_out = '0;
    push(cyc + 1, 1'b0, 1'b0, '0);
  endtask

  task automatic drive_frame(input int tot, input int act, input int nlines, input int vb,
                             input bit intl, input int bad_line, input int rst_line);
    int lif, lt, half;
    logic f, v, h;
    half = intl ? nlines / 2 : nlines;
    for (int ln = 0; ln < nlines; ln++) begin
      lif = ln % half;
      lt  = (ln == bad_line) ? tot + 1 : tot;
      f   = intl && (ln >= half);
      v   = (lif < vb);
      for (int c = 0; c < lt; c++) begin
        @(negedge clk);
        h      = (c < lt - act);
        hvf_in = {f, v, h};
        reset  = (ln == rst_line) && (c == 3);
        if (ln == 0 && c == 0) boundary();
        if (reset) model_reset();
      end
    end
    prev_meas  = {12'(act), 12'(tot), 11'(nlines), intl};
    prev_valid = (bad_line < 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (fmt_change) fmt_seen++;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk("is_ok", is_ok, e.ok);
        chk("fmt_change", fmt_change, e.fmt);
        chk("meas", {number_active, samples_per_line, lines_per_frame, interlaced}, e.out);
        $display("txn cyc=%0d ok=%0b fmt=%0b act=%0d tot=%0d lines=%0d intl=%0b",
                 cyc, is_ok, fmt_change, number_active, samples_per_line, lines_per_frame, interlaced);
      end
    end
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("reset_ok", is_ok, 1'b0);
    chk("reset_meas", {number_active, samples_per_line, lines_per_frame, interlaced}, 36'd0);

    repeat (5) drive_frame(24, 16, 8, 2, 1'b0, -1, -1);
    repeat (3) drive_frame(26, 16, 8, 2, 1'b0, -1, -1);
    repeat (5) drive_frame(24, 16, 10, 2, 1'b1, -1, -1);
    repeat (4) drive_frame(24, 16, 8, 2, 1'b0, -1, -1);
    drive_frame(24, 16, 8, 2, 1'b0, 3, -1);
    repeat (3) drive_frame(24, 16, 8, 2, 1'b0, -1, -1);
    drive_frame(24, 16, 8, 2, 1'b0, -1, 4);
    repeat (5) drive_frame(24, 16, 8, 2, 1'b0, -1, -1);

    @(negedge clk);
    hvf_in = 3'b000;
    for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge clk);
    chk("drain", 36'(sbq.size()), 36'd0);
    chk("final_lock", is_ok, 1'b1);

`ifdef LINE_MEASURE_WATCHDOG_EN
    repeat (8300) @(negedge clk);
    fmt_exp++;
    chk("wd_ok", is_ok, 1'b0);
    chk("wd_hold_act", number_active, 36'd16);
`endif

    repeat (4) @(negedge clk);
    chk("fmt_count", 36'(fmt_seen), 36'(fmt_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
